// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback queue.
package wb_pkg;

    localparam int unsigned WB_RD_W   = 7;
    localparam int unsigned WB_DATA_W = 32;

    typedef struct packed {
        logic [WB_RD_W-1:0]   rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Dual-push, single-pop in-order storage for pending register writes.
// Push A is always the older of two same-edge pushes; entries are exported oldest first.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push_a,
    input  wb_entry_t       entry_a,
    input  logic            push_b,
    input  wb_entry_t       entry_b,
    input  logic            pop,
    output wb_entry_t       head,
    output logic [CntW-1:0] count,
    output wb_entry_t       entries [DEPTH]
);

    wb_entry_t       mem [DEPTH];
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic [CntW-1:0] count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_a) begin
                mem[wr_ptr] <= entry_a;
            end
            // B lands behind A when both push on the same edge.
            if (push_b) begin
                mem[wr_ptr + PtrW'(push_a)] <= entry_b;
            end
            wr_ptr <= wr_ptr + PtrW'(push_a) + PtrW'(push_b);
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            count_q <= count_q + CntW'(push_a) + CntW'(push_b) - CntW'(pop);
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            entries[i] = mem[rd_ptr + PtrW'(i)];
        end
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/wb_queue.sv
// Writeback sequencer: accepts ex/mem results, retires one register write per clock,
// and offers a combinational forward lookup over all pending writes.
module wb_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [6:0]  ex_rd,
    input  logic [31:0] ex_result,
    output logic        ex_ready,
    input  logic        mem_valid,
    input  logic [6:0]  mem_rd,
    input  logic [31:0] mem_result,
    output logic        mem_ready,
    input  logic        wb_hold,
    output logic        Wrenable,
    output logic [6:0]  RdWb,
    output logic [31:0] Result,
    input  logic [6:0]  fwd_rd,
    output logic        fwd_hit,
    output logic [31:0] fwd_data,
    output logic [7:0]  drop_count
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [CntW-1:0] count;
    wb_entry_t       head;
    wb_entry_t       entries [DEPTH];

    logic mem_xfer, ex_xfer;
    logic mem_keep, ex_keep;
    logic mem_drop, ex_drop;
    logic pop;

    logic        wr_en_q;
    logic [6:0]  rd_q;
    logic [31:0] res_q;
    logic [7:0]  drop_q;
    logic [7:0]  drop_d;
    logic [8:0]  drop_sum;

    // Readiness looks only at registered occupancy; a same-edge pop frees nothing.
    assign mem_ready = count < CntW'(DEPTH);
    assign ex_ready  = (count < CntW'(DEPTH - 1)) || (mem_ready && !mem_valid);

    assign mem_xfer = mem_valid && mem_ready;
    assign ex_xfer  = ex_valid && ex_ready;
    assign mem_keep = mem_xfer && (32'(mem_rd) < NUM_REGS);
    assign ex_keep  = ex_xfer && (32'(ex_rd) < NUM_REGS);
    assign mem_drop = mem_xfer && !mem_keep;
    assign ex_drop  = ex_xfer && !ex_keep;
    assign pop      = (count != '0) && !wb_hold;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .push_a (mem_keep),
        .entry_a('{rd: mem_rd, data: mem_result}),
        .push_b (ex_keep),
        .entry_b('{rd: ex_rd, data: ex_result}),
        .pop    (pop),
        .head   (head),
        .count  (count),
        .entries(entries)
    );

    always_comb begin
        drop_sum = {1'b0, drop_q} + 9'(mem_drop) + 9'(ex_drop);
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_en_q <= 1'b0;
            rd_q    <= '0;
            res_q   <= '0;
            drop_q  <= '0;
        end else begin
            drop_q <= drop_d;
            if (pop) begin
                wr_en_q <= 1'b1;
                rd_q    <= head.rd;
                res_q   <= head.data;
            end else begin
                wr_en_q <= 1'b0;
            end
        end
    end

    assign Wrenable   = wr_en_q;
    assign RdWb       = rd_q;
    assign Result     = res_q;
    assign drop_count = drop_q;

    // Oldest-to-youngest scan so the last match (the youngest) wins; the output
    // register is older than every FIFO entry.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (32'(fwd_rd) < NUM_REGS) begin
            if (wr_en_q && (rd_q == fwd_rd)) begin
                fwd_hit  = 1'b1;
                fwd_data = res_q;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                if ((CntW'(i) < count) && (entries[i].rd == fwd_rd)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = entries[i].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Randomised and directed bench for wb_queue against a queue-based reference model.
module tb_wb_queue;
    import wb_pkg::*;

    localparam int DEPTH    = 4;
    localparam int NUM_REGS = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid = 1'b0, mem_valid = 1'b0, wb_hold = 1'b0;
    logic [6:0]  ex_rd = '0, mem_rd = '0, fwd_rd = '0;
    logic [31:0] ex_result = '0, mem_result = '0;
    logic        ex_ready, mem_ready, Wrenable, fwd_hit;
    logic [6:0]  RdWb;
    logic [31:0] Result, fwd_data;
    logic [7:0]  drop_count;

    wb_queue #(
        .DEPTH   (DEPTH),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ex_valid  (ex_valid),
        .ex_rd     (ex_rd),
        .ex_result (ex_result),
        .ex_ready  (ex_ready),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_result(mem_result),
        .mem_ready (mem_ready),
        .wb_hold   (wb_hold),
        .Wrenable  (Wrenable),
        .RdWb      (RdWb),
        .Result    (Result),
        .fwd_rd    (fwd_rd),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending writes in acceptance order plus the output register.
    wb_entry_t   q[$];
    logic        m_we;
    logic [6:0]  m_rd;
    logic [31:0] m_res;
    int          m_drops;
    int          wr_pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_we = 1'b0;
        m_rd = '0;
        m_res = '0;
        m_drops = 0;
    endtask

    function automatic logic exp_mem_ready();
        return q.size() < DEPTH;
    endfunction

    function automatic logic exp_ex_ready();
        return (q.size() < DEPTH - 1) || (q.size() < DEPTH && !mem_valid);
    endfunction

    task automatic check_all();
        logic        hit;
        logic [31:0] data;
        hit  = 1'b0;
        data = '0;
        if (fwd_rd < NUM_REGS) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].rd == fwd_rd) begin
                    hit  = 1'b1;
                    data = q[i].data;
                    break;
                end
            end
            if (!hit && m_we && m_rd == fwd_rd) begin
                hit  = 1'b1;
                data = m_res;
            end
        end
        check("mem_ready", 32'(mem_ready), 32'(exp_mem_ready()));
        check("ex_ready", 32'(ex_ready), 32'(exp_ex_ready()));
        check("Wrenable", 32'(Wrenable), 32'(m_we));
        check("RdWb", 32'(RdWb), 32'(m_rd));
        check("Result", Result, m_res);
        check("drop_count", 32'(drop_count), 32'(m_drops));
        check("fwd_hit", 32'(fwd_hit), 32'(hit));
        check("fwd_data", fwd_data, data);
    endtask

    // Drive one cycle's inputs (called just after a negedge), check, then advance the model.
    task automatic step(input logic mv, input logic [6:0] mrd, input logic [31:0] mres,
                        input logic ev, input logic [6:0] erd, input logic [31:0] eres,
                        input logic hold, input logic [6:0] frd);
        logic mr, er;
        mem_valid = mv; mem_rd = mrd; mem_result = mres;
        ex_valid = ev; ex_rd = erd; ex_result = eres;
        wb_hold = hold; fwd_rd = frd;
        #1;
        check_all();
        mr = exp_mem_ready();
        er = exp_ex_ready();
        @(posedge clock);
        if (q.size() > 0 && !hold) begin
            wb_entry_t e;
            e = q.pop_front();
            m_we = 1'b1; m_rd = e.rd; m_res = e.data;
            wr_pulses++;
        end else begin
            m_we = 1'b0;
        end
        if (mv && mr) begin
            if (mrd < NUM_REGS) q.push_back('{rd: mrd, data: mres});
            else if (m_drops < 255) m_drops++;
        end
        if (ev && er) begin
            if (erd < NUM_REGS) q.push_back('{rd: erd, data: eres});
            else if (m_drops < 255) m_drops++;
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 7'd3);
    endtask

    function automatic logic [6:0] rand_rd();
        return ($urandom_range(0, 9) == 0) ? 7'($urandom_range(32, 127))
                                           : 7'($urandom_range(0, 7));
    endfunction

    initial begin
        model_reset();
        wr_pulses = 0;
        #12;
        reset = 1'b1;
        @(negedge clock);

        // Reset state, then a single write and its two-edge latency.
        idle(1);
        step(0, 0, 0, 1, 7'd5, 32'hDEADBEEF, 0, 7'd5);
        step(0, 0, 0, 0, 0, 0, 0, 7'd5);
        check("single_write_we", 32'(Wrenable), 32'd1);
        check("single_write_rd", 32'(RdWb), 32'd5);
        check("single_write_data", Result, 32'hDEADBEEF);
        idle(2);

        // Same-edge mem/ex to one rd: mem retires first, forward sees the ex value.
        step(1, 7'd3, 32'h11, 1, 7'd3, 32'h22, 0, 7'd3);
        step(0, 0, 0, 0, 0, 0, 0, 7'd3);
        check("order_first", Result, 32'h11);
        check("order_fwd", fwd_data, 32'h22);
        idle(3);

        // Fill under hold, then drain.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 7'(i + 8), 32'hA0 + i, 1, 7'd9);
        check("full_ex_ready", 32'(ex_ready), 32'd0);
        check("full_mem_ready", 32'(mem_ready), 32'd0);
        for (int i = 0; i < 2; i++) step(1, 7'd1, 32'h55, 1, 7'd2, 32'h66, 1, 7'd8);
        idle(6);

        // Out-of-range drops and saturation.
        step(0, 0, 0, 1, 7'd40, 32'h1, 0, 7'd40);
        idle(2);
        check("drop_one", 32'(drop_count), 32'd1);
        for (int i = 0; i < 300; i++) step(0, 0, 0, 1, 7'd40, 32'(i), 0, 7'd40);
        step(1, 7'd99, 32'h2, 1, 7'd64, 32'h3, 0, 7'd0);
        check("drop_sat", 32'(drop_count), 32'd255);

        // Reset mid-operation with pending entries.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 7'(i + 1), 32'hC0 + i, 1, 7'd1);
        step(0, 0, 0, 0, 0, 0, 0, 7'd1);
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_we", 32'(Wrenable), 32'd0);
        check("rst_rd", 32'(RdWb), 32'd0);
        check("rst_result", Result, 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        wr_pulses = 0;
        idle(4);
        check("rst_no_writes", 32'(wr_pulses), 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            logic hold;
            hold = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 1) == 1, rand_rd(), $urandom(),
                 $urandom_range(0, 1) == 1, rand_rd(), $urandom(),
                 hold, ($urandom_range(0, 9) == 0) ? 7'd50 : 7'($urandom_range(0, 8)));
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
